sync_filter_array: RTL and testbench
====================================

// Module: sync_filter_array
// PURPOSE
//  Multi-channel input conditioner for asynchronous level signals (buttons, straps, status pins) entering one clock domain.
//  Per channel: SYNC_FF-stage synchronizer, FILT_LEN-cycle stability filter, registered rise/fall pulses, sticky event flags.
//  Bits are unrelated; no multi-bit coherency is provided. Multi-bit values use a gray-code CDC instead.
// PARAMETERS
//  CH        4   number of independent channels, 1..64
//  SYNC_FF   4   synchronizer stages, 2..10
//  FILT_LEN  8   cycles a new synced level must be stable before dout changes, 1..65535
//  RST_VAL   0   CH-bit reset value of synchronizer stages and dout
// PORTS
//  clk         in   1   single clock; all logic rising-edge
//  rst         in   1   synchronous reset, active-high
//  din         in   CH  asynchronous inputs, no timing relation to clk
//  dout        out  CH  filtered level, registered
//  rise        out  CH  1-cycle pulse, coincident with dout 0->1
//  fall        out  CH  1-cycle pulse, coincident with dout 1->0
//  sticky      out  CH  set on any dout change, held until cleared
//  sticky_clr  in   CH  per-bit clear of sticky, clk domain
//  any_chg     out  1   registered OR of (rise|fall), same cycle as pulses
// BEHAVIOUR
//  Reset (rst=1 at edge): sync stages<=RST_VAL, dout<=RST_VAL, counters<=0, rise/fall/sticky/any_chg<=0.
//   Mid-operation reset aborts any filtering in progress. No pulse is generated on or after reset release.
//   If din differs from RST_VAL after release, the change goes through the normal sync+filter path.
//  Sync: s[0]<=din, s[k]<=s[k-1]. syn=s[SYNC_FF-1]. First stage carries ASYNC_REG attribute, no logic between stages.
//  Filter, per channel, counter width $clog2(FILT_LEN+1):
//   syn==dout: cnt<=0 (pending change abandoned)
//   syn!=dout, cnt<FILT_LEN-1: cnt<=cnt+1
//   syn!=dout, cnt==FILT_LEN-1: dout<=syn, cnt<=0, rise/fall per direction <=1
//   Result: dout changes only after FILT_LEN consecutive edges with syn!=dout.
//   Glitches shorter than FILT_LEN cycles (at syn) are discarded. FILT_LEN=1 gives dout = syn delayed 1 cycle.
//  Latency: din stable from edge 0 -> syn valid by edge SYNC_FF -> dout/rise/fall at edge SYNC_FF+FILT_LEN.
//   Add +1 cycle of metastability uncertainty.
//  rise/fall are high for exactly one cycle and never both in one cycle for a channel.
//   Min spacing between pulses on one channel is FILT_LEN cycles.
//  sticky[i]: set when rise[i]|fall[i] is registered. Cleared when sticky_clr[i]=1.
//   Set and clear in the same cycle: set wins.
//  any_chg: registered |(next rise | next fall), aligned with rise/fall.
//  Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
//  Counters saturate by construction (reset at FILT_LEN-1); no wrap-around.
// TESTING  (CH=4, SYNC_FF=4, FILT_LEN=8, RST_VAL=0 unless stated)
//  1 Reset: hold rst 3 cycles with din=4'hF -> dout=0, rise=fall=sticky=0.
//    After release: rise=4'hF exactly once at edge 12, dout=4'hF.
//  2 Latency: din[0] 0->1 before edge 0 -> rise[0]=1 for one cycle at edge 12, dout[0]=1 from edge 12, any_chg=1 at edge 12.
//  3 Glitch: din[1]=1 for 7 cycles then 0 -> no rise/fall, dout[1] stays 0.
//    Repeat with 8 cycles -> rise[1] at +12, fall[1] at +20.
//  4 Sticky: after a rise on ch2, sticky[2]=1 stays set.
//    Pulse sticky_clr[2] in the same cycle as a new fall[2] -> sticky[2] stays 1.
//    Next clr with no event -> sticky[2]=0.
//  5 Mid-filter reset: din[3]=1, assert rst at edge 9 -> dout[3]=0, cnt cleared.
//    After release, rise[3] at release+12, not earlier.
//  6 Params: FILT_LEN=1, SYNC_FF=2, RST_VAL=4'hA -> reset dout=4'hA.
//    din=4'h5 -> dout=4'h5 at edge 3, rise=4'h5 and fall=4'hA in the same cycle.

Source files
------------

// File: rtl/sync_filter_array.sv
// Multi-channel conditioner for asynchronous level inputs: synchronizer chain,
// stability filter, registered rise/fall pulses, sticky change flags.
module sync_filter_array #(
  parameter int              CH       = 4,
  parameter int              SYNC_FF  = 4,
  parameter int              FILT_LEN = 8,
  parameter logic [CH-1:0]   RST_VAL  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic [CH-1:0] sticky,
  input  logic [CH-1:0] sticky_clr,
  output logic          any_chg
);

  localparam int CW = $clog2(FILT_LEN + 1);

  // First stage may go metastable; keep it packed next to its successor.
  (* ASYNC_REG = "TRUE" *) logic [CH-1:0] meta_reg;
  logic [CH-1:0] sync_reg [SYNC_FF-1];
  logic [CH-1:0] syn;

  logic [CH-1:0] dout_reg, rise_reg, fall_reg, sticky_reg;
  logic          any_chg_reg;
  logic [CH-1:0] dout_next, rise_next, fall_next, sticky_next;

  always_ff @(posedge clk) begin
    if (rst) meta_reg <= RST_VAL;
    else     meta_reg <= din;
  end

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_FF - 1; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= RST_VAL;
          else     sync_reg[gi] <= meta_reg;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= RST_VAL;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign syn = sync_reg[SYNC_FF-2];

  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [CW-1:0] cnt_reg;
      logic          diff;
      logic          hit;

      assign diff = syn[gi] ^ dout_reg[gi];
      assign hit  = diff && (cnt_reg == CW'(FILT_LEN - 1));

      // Counter restarts on agreement or on acceptance, so it never wraps.
      always_ff @(posedge clk) begin
        if (rst)               cnt_reg <= '0;
        else if (!diff || hit) cnt_reg <= '0;
        else                   cnt_reg <= cnt_reg + CW'(1);
      end

      assign dout_next[gi] = hit ? syn[gi] : dout_reg[gi];
      assign rise_next[gi] = hit &  syn[gi];
      assign fall_next[gi] = hit & ~syn[gi];
    end
  endgenerate

  // A new event overrides a clear arriving on the same edge.
  assign sticky_next = (sticky_reg & ~sticky_clr) | rise_next | fall_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg    <= RST_VAL;
      rise_reg    <= '0;
      fall_reg    <= '0;
      sticky_reg  <= '0;
      any_chg_reg <= 1'b0;
    end else begin
      dout_reg    <= dout_next;
      rise_reg    <= rise_next;
      fall_reg    <= fall_next;
      sticky_reg  <= sticky_next;
      any_chg_reg <= |(rise_next | fall_next);
    end
  end

  assign dout    = dout_reg;
  assign rise    = rise_reg;
  assign fall    = fall_reg;
  assign sticky  = sticky_reg;
  assign any_chg = any_chg_reg;

endmodule

// File: tb/tb_sync_filter_array.sv
// Bench for sync_filter_array: directed scenarios plus randomized traffic,
// all compared against a cycle-indexed behavioural model.
module tb_sync_filter_array;

  localparam int CH = 4;
  localparam int SF = 4;
  localparam int FL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [CH-1:0] din, sticky_clr;
  logic [CH-1:0] dout, rise, fall, sticky;
  logic          any_chg;

  logic          rst2;
  logic [3:0]    din2, clr2;
  logic [3:0]    dout2, rise2, fall2, sticky2;
  logic          any2;

  sync_filter_array #(.CH(CH), .SYNC_FF(SF), .FILT_LEN(FL), .RST_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .rise(rise), .fall(fall),
    .sticky(sticky), .sticky_clr(sticky_clr), .any_chg(any_chg)
  );

  sync_filter_array #(.CH(4), .SYNC_FF(2), .FILT_LEN(1), .RST_VAL(4'hA)) dut2 (
    .clk(clk), .rst(rst2), .din(din2), .dout(dout2), .rise(rise2), .fall(fall2),
    .sticky(sticky2), .sticky_clr(clr2), .any_chg(any2)
  );

  int checks = 0;
  int failures = 0;

  // Model: din sampled at edge t is visible as syn from edge t+SF on, unless a
  // reset edge intervened; dout flips after FL consecutive edges of disagreement.
  logic [CH-1:0] din_log [$];
  int            t = 0;
  int            last_rst = -1000;
  int            run [CH];
  logic [CH-1:0] m_dout, m_rise, m_fall, m_sticky;
  logic          m_any;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_edge(input logic r, input logic [CH-1:0] d, input logic [CH-1:0] c);
    logic [CH-1:0] syn;
    if (r) begin
      m_dout = '0; m_rise = '0; m_fall = '0; m_sticky = '0; m_any = 1'b0;
      for (int i = 0; i < CH; i++) run[i] = 0;
      last_rst = t;
    end else begin
      if (t - SF > last_rst && t - SF >= 0) syn = din_log[t-SF];
      else                                  syn = '0;
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < CH; i++) begin
        if (syn[i] != m_dout[i]) begin
          run[i]++;
          if (run[i] == FL) begin
            run[i] = 0;
            if (syn[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            m_dout[i] = syn[i];
          end
        end else begin
          run[i] = 0;
        end
      end
      m_sticky = (m_sticky & ~c) | m_rise | m_fall;
      m_any = |(m_rise | m_fall);
    end
    din_log.push_back(d);
    t++;
  endtask

  task automatic step(input logic r, input logic [CH-1:0] d, input logic [CH-1:0] c);
    rst = r; din = d; sticky_clr = c;
    @(posedge clk);
    model_edge(r, d, c);
    #1;
    chk("dout", dout, m_dout);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("sticky", sticky, m_sticky);
    chk("any_chg", {3'b0, any_chg}, {3'b0, m_any});
    $display("t=%0d rst=%b din=%h clr=%h dout=%h rise=%h fall=%h sticky=%h any=%b",
             t, r, d, c, dout, rise, fall, sticky, any_chg);
  endtask

  logic [CH-1:0] rd, rc;
  logic          rr;

  initial begin
    rst = 1'b1; din = '0; sticky_clr = '0;
    rst2 = 1'b1; din2 = 4'h0; clr2 = 4'h0;

    // Reset held with all inputs high, then the change propagates normally.
    for (int k = 0; k < 3; k++) step(1'b1, 4'hF, 4'h0);
    chk("t1_rst_dout", dout, 4'h0);
    chk("t1_rst_rise", rise, 4'h0);
    chk("t1_rst_sticky", sticky, 4'h0);
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 4'hF, 4'h0);
      if (k == 11) chk("t1_rise_early", rise, 4'h0);
      if (k == 12) begin chk("t1_rise", rise, 4'hF); chk("t1_dout", dout, 4'hF); end
      if (k == 13) chk("t1_rise_once", rise, 4'h0);
    end

    // Single-channel latency.
    step(1'b1, 4'h0, 4'h0);
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 4'h1, 4'h0);
      if (k == 11) chk("t2_dout_early", dout, 4'h0);
      if (k == 12) begin
        chk("t2_rise", rise, 4'h1); chk("t2_dout", dout, 4'h1);
        chk("t2_any", {3'b0, any_chg}, 4'h1);
      end
      if (k == 13) chk("t2_rise_once", rise, 4'h0);
    end

    // Glitch of FILT_LEN-1 cycles is discarded; FILT_LEN cycles pass.
    for (int k = 1; k <= 22; k++) begin
      step(1'b0, (k <= 7) ? 4'h3 : 4'h1, 4'h0);
      chk("t3_glitch_dout", dout & 4'h2, 4'h0);
      chk("t3_glitch_pulse", (rise | fall) & 4'h2, 4'h0);
    end
    for (int k = 1; k <= 22; k++) begin
      step(1'b0, (k <= 8) ? 4'h3 : 4'h1, 4'h0);
      if (k == 12) chk("t3_rise1", rise, 4'h2);
      if (k == 20) chk("t3_fall1", fall, 4'h2);
    end

    // Sticky: set by rise, survives a clear coincident with a fall, then clears.
    step(1'b0, 4'h1, 4'hF);
    chk("t4_cleared", sticky, 4'h0);
    for (int k = 1; k <= 16; k++) step(1'b0, 4'h5, 4'h0);
    chk("t4_sticky_set", sticky & 4'h4, 4'h4);
    for (int k = 1; k <= 13; k++) begin
      step(1'b0, 4'h1, (k == 12 || k == 13) ? 4'h4 : 4'h0);
      if (k == 12) begin chk("t4_fall", fall, 4'h4); chk("t4_set_wins", sticky & 4'h4, 4'h4); end
      if (k == 13) chk("t4_clr", sticky & 4'h4, 4'h0);
    end

    // Reset in the middle of a pending change.
    step(1'b1, 4'h0, 4'h0);
    for (int k = 1; k <= 9; k++) step(k == 9, 4'h8, 4'h0);
    chk("t5_rst_dout", dout, 4'h0);
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 4'h8, 4'h0);
      if (k < 12)  chk("t5_no_early_rise", rise, 4'h0);
      if (k == 12) chk("t5_rise3", rise, 4'h8);
    end

    // Randomized traffic against the model.
    rd = din;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) rd[$urandom_range(0, CH-1)] ^= 1'b1;
      rc = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
      rr = ($urandom_range(0, 199) == 0);
      step(rr, rd, rc);
    end

    // Second instance: FILT_LEN=1, SYNC_FF=2, RST_VAL=A.
    rst2 = 1'b1; din2 = 4'h0;
    @(posedge clk); #1;
    chk("t6_rst_dout", dout2, 4'hA);
    rst2 = 1'b0; din2 = 4'h5;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      $display("dut2 k=%0d dout=%h rise=%h fall=%h any=%b", k, dout2, rise2, fall2, any2);
      if (k == 2) chk("t6_dout_early", dout2, 4'hA);
      if (k == 3) begin
        chk("t6_dout", dout2, 4'h5); chk("t6_rise", rise2, 4'h5);
        chk("t6_fall", fall2, 4'hA); chk("t6_any", {3'b0, any2}, 4'h1);
      end
      if (k == 4) chk("t6_pulse_once", rise2 | fall2, 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
